thermal_plane_packer: RTL and testbench

- Downstream of the thermometer encoder in the BNN input path.
- Takes one encoded pixel per cycle (INPUT_WIDTH thermometer bits plus per-bit write enables) and transposes the stream into bit-planes.
- Packs PACK_WIDTH consecutive pixels per plane into one word and drains the INPUT_WIDTH plane words over a valid/ready interface to the binary input buffer.
- Tracks a fixed-size frame of NUM_PIXELS pixels; the final partial word is zero-padded and flagged last.

---
 rtl/thermal_plane_packer_if.sv | 31 +++
 rtl/thermal_plane_packer.sv | 147 ++++++++++++++
 tb/tb_thermal_plane_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/thermal_plane_packer_if.sv
// Pixel-in / plane-word-out bundle for the thermometer bit-plane packer.
// master = packer side, slave = encoder plus binary input buffer side.
interface thermal_plane_packer_if #(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned PACK_WIDTH  = 32,
    parameter int unsigned NUM_PIXELS  = 784
);
    localparam int unsigned WORDS_PER_PLANE = (NUM_PIXELS + PACK_WIDTH - 1) / PACK_WIDTH;
    localparam int unsigned PLANE_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int unsigned WIDX_W  = (WORDS_PER_PLANE > 1) ? $clog2(WORDS_PER_PLANE) : 1;

    logic [INPUT_WIDTH-1:0] encoded_in;
    logic [INPUT_WIDTH-1:0] write_en_in;
    logic                   in_ready;
    logic [PACK_WIDTH-1:0]  out_data;
    logic [PLANE_W-1:0]     out_plane;
    logic [WIDX_W-1:0]      out_word_idx;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    modport master (
        input  encoded_in, write_en_in, out_ready,
        output in_ready, out_data, out_plane, out_word_idx, out_valid, out_last
    );

    modport slave (
        output encoded_in, write_en_in, out_ready,
        input  in_ready, out_data, out_plane, out_word_idx, out_valid, out_last
    );
endinterface

// File: rtl/thermal_plane_packer.sv
// Transposes thermometer-coded pixels into bit-planes, packing PACK_WIDTH
// pixels per plane word and draining planes 0..INPUT_WIDTH-1 downstream.
module thermal_plane_packer #(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned PACK_WIDTH  = 32,
    parameter int unsigned NUM_PIXELS  = 784
) (
    input logic clk,
    input logic rst_n,
    thermal_plane_packer_if.master bus
);
    localparam int unsigned WORDS_PER_PLANE = (NUM_PIXELS + PACK_WIDTH - 1) / PACK_WIDTH;
    localparam int unsigned PLANE_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int unsigned WIDX_W  = (WORDS_PER_PLANE > 1) ? $clog2(WORDS_PER_PLANE) : 1;
    localparam int unsigned SLOT_W  = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
    localparam int unsigned PIX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    typedef enum logic {COLLECT, DRAIN} state_e;

    state_e                                  state_q, state_d;
    logic [INPUT_WIDTH-1:0][PACK_WIDTH-1:0]  coll_q, coll_d;
    logic [INPUT_WIDTH-1:0][PACK_WIDTH-1:0]  drain_q, drain_d;
    logic [SLOT_W-1:0]                       slot_q, slot_d;
    logic [PIX_W-1:0]                        pixel_q, pixel_d;
    logic [WIDX_W-1:0]                       word_q, word_d;
    logic [PLANE_W-1:0]                      plane_q, plane_d;
    logic                                    frame_last_q, frame_last_d;
    logic                                    in_ready_q, in_ready_d;
    logic                                    out_valid_q, out_valid_d;
    logic                                    out_last_q, out_last_d;

    logic                   accept_c;
    logic                   hs_c;
    logic [INPUT_WIDTH-1:0] pix_bits_c;
    logic [PACK_WIDTH-1:0]  slot_mask_c;

    assign accept_c   = in_ready_q & (|bus.write_en_in);
    assign hs_c       = out_valid_q & bus.out_ready;
    assign pix_bits_c = bus.encoded_in & bus.write_en_in;

    always_comb begin
        for (int k = 0; k < int'(PACK_WIDTH); k++) begin
            slot_mask_c[k] = (k <= int'(slot_q));
        end
    end

    // Next-state: collect pixels into plane slots, then drain one plane per handshake.
    always_comb begin
        state_d      = state_q;
        coll_d       = coll_q;
        drain_d      = drain_q;
        slot_d       = slot_q;
        pixel_d      = pixel_q;
        word_d       = word_q;
        plane_d      = plane_q;
        frame_last_d = frame_last_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;

        unique case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
                        coll_d[i][slot_q] = pix_bits_c[i];
                    end
                    slot_d  = slot_q + SLOT_W'(1);
                    pixel_d = pixel_q + PIX_W'(1);
                    if (slot_q == SLOT_W'(PACK_WIDTH - 1) || pixel_q == PIX_W'(NUM_PIXELS - 1)) begin
                        for (int i = 0; i < int'(INPUT_WIDTH); i++) begin
                            drain_d[i] = coll_d[i] & slot_mask_c;
                        end
                        coll_d       = '0;
                        frame_last_d = (pixel_q == PIX_W'(NUM_PIXELS - 1));
                        plane_d      = '0;
                        in_ready_d   = 1'b0;
                        out_valid_d  = 1'b1;
                        out_last_d   = frame_last_d && (INPUT_WIDTH == 1);
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs_c) begin
                    // Plane 0 is always at the bottom; shift the next plane into view.
                    drain_d = drain_q >> PACK_WIDTH;
                    if (plane_q == PLANE_W'(INPUT_WIDTH - 1)) begin
                        plane_d     = '0;
                        slot_d      = '0;
                        coll_d      = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = COLLECT;
                        if (frame_last_q) begin
                            pixel_d = '0;
                            word_d  = '0;
                        end else begin
                            word_d  = word_q + WIDX_W'(1);
                        end
                    end else begin
                        plane_d    = plane_q + PLANE_W'(1);
                        out_last_d = frame_last_q &&
                                     ((plane_q + PLANE_W'(1)) == PLANE_W'(INPUT_WIDTH - 1));
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            coll_q       <= '0;
            drain_q      <= '0;
            slot_q       <= '0;
            pixel_q      <= '0;
            word_q       <= '0;
            plane_q      <= '0;
            frame_last_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            coll_q       <= coll_d;
            drain_q      <= drain_d;
            slot_q       <= slot_d;
            pixel_q      <= pixel_d;
            word_q       <= word_d;
            plane_q      <= plane_d;
            frame_last_q <= frame_last_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = drain_q[0];
    assign bus.out_plane    = plane_q;
    assign bus.out_word_idx = word_q;
    assign bus.out_last     = out_last_q;

endmodule

// File: tb/tb_thermal_plane_packer.sv
// Directed bench: cycle table on a 4-pixel/8-pixel-frame packer, plus hand
// sequences for a partial last word and a mid-drain reset at full size.
module tb_thermal_plane_packer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] enc;
    logic [7:0] wen;
    logic       ordy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    thermal_plane_packer_if #(.INPUT_WIDTH(8), .PACK_WIDTH(4),  .NUM_PIXELS(8))   ifa ();
    thermal_plane_packer_if #(.INPUT_WIDTH(8), .PACK_WIDTH(4),  .NUM_PIXELS(6))   ifb ();
    thermal_plane_packer_if #(.INPUT_WIDTH(8), .PACK_WIDTH(32), .NUM_PIXELS(784)) ifc ();

    assign ifa.encoded_in = enc;  assign ifa.write_en_in = wen;  assign ifa.out_ready = ordy;
    assign ifb.encoded_in = enc;  assign ifb.write_en_in = wen;  assign ifb.out_ready = ordy;
    assign ifc.encoded_in = enc;  assign ifc.write_en_in = wen;  assign ifc.out_ready = ordy;

    thermal_plane_packer #(.INPUT_WIDTH(8), .PACK_WIDTH(4), .NUM_PIXELS(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    thermal_plane_packer #(.INPUT_WIDTH(8), .PACK_WIDTH(4), .NUM_PIXELS(6))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    thermal_plane_packer #(.INPUT_WIDTH(8), .PACK_WIDTH(32), .NUM_PIXELS(784))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        logic [7:0] enc;
        logic [7:0] wen;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_pl;
        logic [3:0] e_dat;
        logic       e_wi;
        logic       e_last;
    } vec_t;

    localparam int NV = 37;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [7:0] e, input logic [7:0] w, input logic r,
                                input logic ir, input logic ov, input logic [2:0] pl,
                                input logic [3:0] dat, input logic wi, input logic last);
        vec_t v;
        v.enc = e; v.wen = w; v.ordy = r; v.e_ir = ir; v.e_ov = ov;
        v.e_pl = pl; v.e_dat = dat; v.e_wi = wi; v.e_last = last;
        return v;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wen   = 8'h00;
        enc   = 8'h00;
        ordy  = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        enc = 8'h00; wen = 8'h00; ordy = 1'b1; rst_n = 1'b0;

        // Basic pack, enable masking, dropped input during drain, 5-cycle stall on plane 3.
        tbl[0]  = mk(8'hFF, 8'hFF, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[1]  = mk(8'h00, 8'hFF, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[2]  = mk(8'hAA, 8'h00, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[3]  = mk(8'h55, 8'h00, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[4]  = mk(8'hFF, 8'h00, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[5]  = mk(8'h0F, 8'hFF, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[6]  = mk(8'h01, 8'hFF, 1, 0, 1, 0, 4'b1101, 0, 0);
        tbl[7]  = mk(8'hFF, 8'hFF, 1, 0, 1, 1, 4'b0101, 0, 0);
        tbl[8]  = mk(8'hFF, 8'hFF, 1, 0, 1, 2, 4'b0101, 0, 0);
        tbl[9]  = mk(8'hFF, 8'hFF, 1, 0, 1, 3, 4'b0101, 0, 0);
        for (int r = 10; r < 15; r++) tbl[r] = mk(8'hFF, 8'hFF, 0, 0, 1, 3, 4'b0101, 0, 0);
        tbl[15] = mk(8'hFF, 8'hFF, 1, 0, 1, 4, 4'b0001, 0, 0);
        tbl[16] = mk(8'hFF, 8'hFF, 1, 0, 1, 5, 4'b0001, 0, 0);
        tbl[17] = mk(8'hFF, 8'hFF, 1, 0, 1, 6, 4'b0001, 0, 0);
        tbl[18] = mk(8'hFF, 8'hFF, 1, 0, 1, 7, 4'b0001, 0, 0);
        tbl[19] = mk(8'hFF, 8'hFF, 1, 1, 0, 0, 4'b0000, 1, 0);
        tbl[20] = mk(8'hFF, 8'h0F, 1, 1, 0, 0, 4'b0000, 1, 0);
        tbl[21] = mk(8'h03, 8'hFF, 1, 1, 0, 0, 4'b0000, 1, 0);
        tbl[22] = mk(8'hFF, 8'hFF, 1, 1, 0, 0, 4'b0000, 1, 0);
        tbl[23] = mk(8'h80, 8'hFF, 1, 0, 1, 0, 4'b0111, 1, 0);
        tbl[24] = mk(8'h00, 8'h00, 1, 0, 1, 1, 4'b0111, 1, 0);
        tbl[25] = mk(8'h00, 8'h00, 1, 0, 1, 2, 4'b0101, 1, 0);
        tbl[26] = mk(8'h00, 8'h00, 1, 0, 1, 3, 4'b0101, 1, 0);
        tbl[27] = mk(8'h00, 8'h00, 1, 0, 1, 4, 4'b0100, 1, 0);
        tbl[28] = mk(8'h00, 8'h00, 1, 0, 1, 5, 4'b0100, 1, 0);
        tbl[29] = mk(8'h00, 8'h00, 1, 0, 1, 6, 4'b0100, 1, 0);
        tbl[30] = mk(8'h00, 8'h00, 1, 0, 1, 7, 4'b1100, 1, 1);
        tbl[31] = mk(8'h00, 8'h00, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[32] = mk(8'h01, 8'hFF, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[33] = mk(8'h02, 8'hFF, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[34] = mk(8'h04, 8'hFF, 1, 1, 0, 0, 4'b0000, 0, 0);
        tbl[35] = mk(8'h08, 8'hFF, 1, 0, 1, 0, 4'b0001, 0, 0);
        tbl[36] = mk(8'h00, 8'h00, 1, 0, 1, 1, 4'b0010, 0, 0);

        step();
        step();
        chk("rst in_ready a",  64'(ifa.in_ready), 1);
        chk("rst out_valid a", 64'(ifa.out_valid), 0);
        chk("rst out_last a",  64'(ifa.out_last), 0);
        chk("rst out_data a",  64'(ifa.out_data), 0);
        chk("rst out_plane a", 64'(ifa.out_plane), 0);
        chk("rst word_idx a",  64'(ifa.out_word_idx), 0);
        chk("rst in_ready c",  64'(ifc.in_ready), 1);
        chk("rst out_valid c", 64'(ifc.out_valid), 0);
        rst_n = 1'b1;

        for (int r = 0; r < NV; r++) begin
            enc  = tbl[r].enc;
            wen  = tbl[r].wen;
            ordy = tbl[r].ordy;
            step();
            chk($sformatf("r%0d in_ready", r),  64'(ifa.in_ready),     64'(tbl[r].e_ir));
            chk($sformatf("r%0d out_valid", r), 64'(ifa.out_valid),    64'(tbl[r].e_ov));
            chk($sformatf("r%0d out_plane", r), 64'(ifa.out_plane),    64'(tbl[r].e_pl));
            chk($sformatf("r%0d out_data", r),  64'(ifa.out_data),     64'(tbl[r].e_dat));
            chk($sformatf("r%0d word_idx", r),  64'(ifa.out_word_idx), 64'(tbl[r].e_wi));
            chk($sformatf("r%0d out_last", r),  64'(ifa.out_last),     64'(tbl[r].e_last));
        end

        // Partial final word on the 6-pixel frame.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            enc = 8'hFF; wen = 8'hFF;
            step();
        end
        wen = 8'h00;
        chk("b w0 out_valid", 64'(ifb.out_valid), 1);
        chk("b w0 word_idx",  64'(ifb.out_word_idx), 0);
        for (int pl = 0; pl < 8; pl++) begin
            chk($sformatf("b w0 p%0d plane", pl), 64'(ifb.out_plane), 64'(pl));
            chk($sformatf("b w0 p%0d data", pl),  64'(ifb.out_data), 64'hF);
            chk($sformatf("b w0 p%0d last", pl),  64'(ifb.out_last), 0);
            step();
        end
        chk("b w0 in_ready back", 64'(ifb.in_ready), 1);
        for (int p = 0; p < 2; p++) begin
            enc = 8'hFF; wen = 8'hFF;
            step();
        end
        wen = 8'h00;
        chk("b w1 out_valid", 64'(ifb.out_valid), 1);
        chk("b w1 word_idx",  64'(ifb.out_word_idx), 1);
        for (int pl = 0; pl < 8; pl++) begin
            chk($sformatf("b w1 p%0d plane", pl), 64'(ifb.out_plane), 64'(pl));
            chk($sformatf("b w1 p%0d data", pl),  64'(ifb.out_data), 64'h3);
            chk($sformatf("b w1 p%0d last", pl),  64'(ifb.out_last), (pl == 7) ? 64'd1 : 64'd0);
            step();
        end
        chk("b wrap in_ready",  64'(ifb.in_ready), 1);
        chk("b wrap out_valid", 64'(ifb.out_valid), 0);
        chk("b wrap word_idx",  64'(ifb.out_word_idx), 0);
        for (int p = 0; p < 4; p++) begin
            enc = 8'h01; wen = 8'hFF;
            step();
        end
        wen = 8'h00;
        chk("b wrap w0 valid", 64'(ifb.out_valid), 1);
        chk("b wrap w0 idx",   64'(ifb.out_word_idx), 0);
        chk("b wrap w0 data",  64'(ifb.out_data), 64'hF);

        // Full-size packer: reset asserted in the middle of a drain.
        do_reset();
        for (int p = 0; p < 32; p++) begin
            enc = 8'(p); wen = 8'hFF;
            step();
        end
        wen = 8'h00;
        chk("c w0 out_valid", 64'(ifc.out_valid), 1);
        chk("c w0 plane0",    64'(ifc.out_data), 64'hAAAA_AAAA);
        step(); step(); step();
        chk("c mid plane", 64'(ifc.out_plane), 3);
        rst_n = 1'b0;
        #2;
        chk("c async out_valid", 64'(ifc.out_valid), 0);
        chk("c async in_ready",  64'(ifc.in_ready), 1);
        chk("c async out_plane", 64'(ifc.out_plane), 0);
        chk("c async out_data",  64'(ifc.out_data), 0);
        step();
        rst_n = 1'b1;
        for (int p = 0; p < 31; p++) begin
            enc = 8'hFF; wen = 8'hFF;
            step();
        end
        chk("c no early valid", 64'(ifc.out_valid), 0);
        enc = 8'hFF; wen = 8'hFF;
        step();
        wen = 8'h00;
        chk("c after rst valid", 64'(ifc.out_valid), 1);
        chk("c after rst idx",   64'(ifc.out_word_idx), 0);
        chk("c after rst data",  64'(ifc.out_data), 64'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
